// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the EX-stage multiply/divide unit.
package mdu_pkg;

    localparam int unsigned CNT_W            = 4;
    localparam int unsigned MULT_CYCLES_DEF  = 5;
    localparam int unsigned DIV_CYCLES_DEF   = 10;

    localparam logic [3:0] MDU_OP_NONE  = 4'd0;
    localparam logic [3:0] MDU_OP_MULT  = 4'd1;
    localparam logic [3:0] MDU_OP_MULTU = 4'd2;
    localparam logic [3:0] MDU_OP_DIV   = 4'd3;
    localparam logic [3:0] MDU_OP_DIVU  = 4'd4;
    localparam logic [3:0] MDU_OP_MTHI  = 4'd5;
    localparam logic [3:0] MDU_OP_MTLO  = 4'd6;
    localparam logic [3:0] MDU_OP_MFHI  = 4'd7;
    localparam logic [3:0] MDU_OP_MFLO  = 4'd8;

    // Undefined encodings behave as NONE and are never accepted.
    function automatic logic op_is_valid(input logic [3:0] op);
        return (op >= MDU_OP_MULT) && (op <= MDU_OP_MFLO);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational mult/multu/div/divu datapath operating on latched operands.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [63:0] o_hilo,
    output logic        o_div_by_zero
);

    logic        w_signed;
    logic        w_is_div;
    logic [63:0] w_ext_a;
    logic [63:0] w_ext_b;
    logic [63:0] w_prod;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_b_safe;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_quo_s;
    logic [31:0] w_rem_s;

    assign w_signed = (i_op == MDU_OP_MULT) || (i_op == MDU_OP_DIV);
    assign w_is_div = (i_op == MDU_OP_DIV) || (i_op == MDU_OP_DIVU);

    // Low 64 bits of the product of extended operands equal the signed/unsigned product.
    assign w_ext_a = {{32{w_signed & i_a[31]}}, i_a};
    assign w_ext_b = {{32{w_signed & i_b[31]}}, i_b};
    assign w_prod  = w_ext_a * w_ext_b;

    // Magnitude division keeps 0x80000000 / -1 well defined (quotient wraps to 0x80000000).
    assign w_a_neg  = w_signed & i_a[31];
    assign w_b_neg  = w_signed & i_b[31];
    assign w_a_mag  = w_a_neg ? (32'd0 - i_a) : i_a;
    assign w_b_mag  = w_b_neg ? (32'd0 - i_b) : i_b;
    assign w_b_safe = (i_b == 32'd0) ? 32'd1 : w_b_mag;
    assign w_quo    = w_a_mag / w_b_safe;
    assign w_rem    = w_a_mag % w_b_safe;
    assign w_quo_s  = (w_a_neg ^ w_b_neg) ? (32'd0 - w_quo) : w_quo;
    assign w_rem_s  = w_a_neg ? (32'd0 - w_rem) : w_rem;

    assign o_div_by_zero = w_is_div && (i_b == 32'd0);

    always_comb begin
        o_hilo = '0;
        case (i_op)
            MDU_OP_MULT, MDU_OP_MULTU: o_hilo = w_prod;
            MDU_OP_DIV, MDU_OP_DIVU:   o_hilo = {w_rem_s, w_quo_s};
            default:                   o_hilo = '0;
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// EX-stage multiply/divide unit: HI/LO state, multi-cycle busy counter, MT/MF access.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] mlu_res,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic [3:0]       r_op;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;

    logic             w_accept;
    logic [63:0]      w_hilo;
    logic             w_div_by_zero;

    assign w_accept = start && !r_busy && op_is_valid(mdu_op);

    mdu_calc u_calc (
        .i_op          (r_op),
        .i_a           (r_a),
        .i_b           (r_b),
        .o_hilo        (w_hilo),
        .o_div_by_zero (w_div_by_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_op   <= MDU_OP_NONE;
            r_a    <= '0;
            r_b    <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else if (r_busy) begin
            // Requests arriving while busy are dropped entirely.
            if (r_cnt == CNT_W'(1)) begin
                r_cnt  <= '0;
                r_busy <= 1'b0;
                if (!w_div_by_zero) begin
                    r_hi <= w_hilo[63:32];
                    r_lo <= w_hilo[31:0];
                end
            end else begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end else if (w_accept) begin
            case (mdu_op)
                MDU_OP_MULT, MDU_OP_MULTU: begin
                    r_op   <= mdu_op;
                    r_a    <= rs_val;
                    r_b    <= rt_val;
                    r_cnt  <= CNT_W'(MULT_CYCLES);
                    r_busy <= 1'b1;
                end
                MDU_OP_DIV, MDU_OP_DIVU: begin
                    r_op   <= mdu_op;
                    r_a    <= rs_val;
                    r_b    <= rt_val;
                    r_cnt  <= CNT_W'(DIV_CYCLES);
                    r_busy <= 1'b1;
                end
                MDU_OP_MTHI: r_hi <= rs_val;
                MDU_OP_MTLO: r_lo <= rs_val;
                default: ;
            endcase
        end
    end

    always_comb begin
        mlu_res = '0;
        case (mdu_op)
            MDU_OP_MFHI: mlu_res = r_hi;
            MDU_OP_MFLO: mlu_res = r_lo;
            default:     mlu_res = '0;
        endcase
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: per-cycle compare against an arithmetic model plus directed checks.
module tb_mdu_unit;
    import mdu_pkg::*;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  mdu_op = MDU_OP_NONE;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        busy;
    logic [31:0] mlu_res;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    mdu_unit #(
        .MULT_CYCLES (MC),
        .DIV_CYCLES  (DC)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mdu_op  (mdu_op),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .busy    (busy),
        .mlu_res (mlu_res),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: results computed with wide integer arithmetic at acceptance time.
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    int          m_rem = 0;
    logic        m_pv = 1'b0;
    logic [63:0] m_pend = '0;

    function automatic logic [64:0] model_calc(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          ps;
        longint unsigned pu;
        longint          q;
        longint          r;
        logic [31:0]     uq;
        logic [31:0]     ur;
        case (op)
            MDU_OP_MULT: begin
                ps = longint'($signed(a)) * longint'($signed(b));
                return {1'b1, ps[63:0]};
            end
            MDU_OP_MULTU: begin
                pu = longint'({32'd0, a}) * longint'({32'd0, b});
                return {1'b1, pu[63:0]};
            end
            MDU_OP_DIV: begin
                if (b == 32'd0) return '0;
                q = longint'($signed(a)) / longint'($signed(b));
                r = longint'($signed(a)) % longint'($signed(b));
                return {1'b1, r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return '0;
                uq = a / b;
                ur = a % b;
                return {1'b1, ur, uq};
            end
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        logic [64:0] res;
        if (!reset) begin
            m_hi = '0; m_lo = '0; m_rem = 0; m_pv = 1'b0; m_pend = '0;
        end else if (m_rem > 0) begin
            m_rem = m_rem - 1;
            if (m_rem == 0 && m_pv) begin
                m_hi = m_pend[63:32];
                m_lo = m_pend[31:0];
            end
        end else if (start) begin
            case (mdu_op)
                MDU_OP_MULT, MDU_OP_MULTU, MDU_OP_DIV, MDU_OP_DIVU: begin
                    res    = model_calc(mdu_op, rs_val, rt_val);
                    m_pv   = res[64];
                    m_pend = res[63:0];
                    m_rem  = (mdu_op == MDU_OP_MULT || mdu_op == MDU_OP_MULTU) ? MC : DC;
                end
                MDU_OP_MTHI: m_hi = rs_val;
                MDU_OP_MTLO: m_lo = rs_val;
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_busy", {31'd0, busy}, {31'd0, (m_rem > 0)});
            chk("cyc_hi", hi, m_hi);
            chk("cyc_lo", lo, m_lo);
            chk("cyc_mlu_res", mlu_res,
                (mdu_op == MDU_OP_MFHI) ? m_hi : (mdu_op == MDU_OP_MFLO) ? m_lo : 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; mdu_op = op; rs_val = a; rt_val = b;
        step();
        start = 1'b0; mdu_op = MDU_OP_NONE;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            step();
        end
    endtask

    task automatic read_mf(input logic [3:0] op, input string name, input logic [31:0] exp);
        start = 1'b1; mdu_op = op;
        #1;
        chk(name, mlu_res, exp);
        step();
        start = 1'b0; mdu_op = MDU_OP_NONE;
    endtask

    initial begin
        int n;
        #2 reset = 1'b0;
        #1 cmp_en = 1'b1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        step(); step();
        reset = 1'b1;
        step();

        issue(MDU_OP_MULT, 32'hFFFF_FFFE, 32'd3);
        wait_idle(n);
        chk("mult_busy_len", n, 32'd5);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);

        issue(MDU_OP_MULTU, 32'hFFFF_FFFE, 32'd3);
        wait_idle(n);
        chk("multu_hi", hi, 32'h0000_0002);
        chk("multu_lo", lo, 32'hFFFF_FFFA);

        issue(MDU_OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        chk("div_busy_len", n, 32'd10);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        issue(MDU_OP_DIVU, 32'd7, 32'd2);
        wait_idle(n);
        chk("divu_lo", lo, 32'd3);
        chk("divu_hi", hi, 32'd1);
        read_mf(MDU_OP_MFHI, "b2b_mfhi", 32'd1);

        issue(MDU_OP_MTHI, 32'h1234_5678, 32'd0);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        read_mf(MDU_OP_MFHI, "mfhi", 32'h1234_5678);
        issue(MDU_OP_MTLO, 32'h0BAD_F00D, 32'd0);
        chk("mtlo_busy", {31'd0, busy}, 32'd0);
        read_mf(MDU_OP_MFLO, "mflo", 32'h0BAD_F00D);

        issue(MDU_OP_MTHI, 32'hAAAA_0000, 32'd0);
        issue(MDU_OP_MTLO, 32'h0000_BBBB, 32'd0);
        issue(MDU_OP_DIV, 32'd5, 32'd0);
        wait_idle(n);
        chk("dz_busy_len", n, 32'd10);
        chk("dz_hi", hi, 32'hAAAA_0000);
        chk("dz_lo", lo, 32'h0000_BBBB);

        issue(MDU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        chk("ovf_lo", lo, 32'h8000_0000);
        chk("ovf_hi", hi, 32'd0);

        issue(MDU_OP_MULT, 32'd6, 32'd7);
        step();
        start = 1'b1; mdu_op = MDU_OP_MTLO; rs_val = 32'h0000_DEAD; rt_val = 32'd99;
        step();
        start = 1'b0; mdu_op = MDU_OP_NONE; rs_val = 32'd123; rt_val = 32'd456;
        wait_idle(n);
        chk("ign_busy_len", n + 2, 32'd5);
        chk("ign_hi", hi, 32'd0);
        chk("ign_lo", lo, 32'd42);

        issue(MDU_OP_DIVU, 32'd100, 32'd7);
        step(); step(); step();
        reset = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        step();
        reset = 1'b1;
        repeat (10) step();
        chk("late_busy", {31'd0, busy}, 32'd0);
        chk("late_hi", hi, 32'd0);
        chk("late_lo", lo, 32'd0);

        @(negedge clk);
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
